// File: rtl/dot_product_sched.sv
// Job sequencer for the signed dot-product array: streams LEN chunks in, sums both partials per retired chunk.
// Result valid ARR_LAT edges after the last accepted chunk; chunk_ready_o closes once LEN are issued, result held until res_ready_i.
module dot_product_sched #(
  parameter int IN_SIZE_0  = 4,
  parameter int IN_SIZE_1  = 8,
  parameter int ARRAY_SIZE = 8,
  parameter int ARR_LAT    = 3,
  parameter int MAX_LEN    = 16,
  localparam int OUT_SIZE  = IN_SIZE_0 + IN_SIZE_1 + ($clog2(((IN_SIZE_1 + 2) / 3) * ARRAY_SIZE) - 1) * 2,
  localparam int ACC_SIZE  = OUT_SIZE + 1 + $clog2(MAX_LEN),
  localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              start_i,
  input  logic [LEN_W-1:0]                  len_i,
  input  logic                              abort_i,
  input  logic                              chunk_valid_i,
  output logic                              chunk_ready_o,
  input  logic [ARRAY_SIZE*IN_SIZE_0-1:0]   chunk_a_i,
  input  logic [ARRAY_SIZE*IN_SIZE_1-1:0]   chunk_b_i,
  output logic [ARRAY_SIZE*IN_SIZE_0-1:0]   arr_in_0_o,
  output logic [ARRAY_SIZE*IN_SIZE_1-1:0]   arr_in_1_o,
  input  logic [2*OUT_SIZE-1:0]             arr_out_i,
  output logic                              res_valid_o,
  input  logic                              res_ready_i,
  output logic [ACC_SIZE-1:0]               res_o,
  output logic                              busy_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  logic [1:0]                 state;
  logic [LEN_W-1:0]           len_q;
  logic [LEN_W-1:0]           issued;
  logic [LEN_W-1:0]           retired;
  logic [ARR_LAT-1:0]         vld_sr;
  logic [ARR_LAT-1:0]         vld_sr_nxt;
  logic signed [ACC_SIZE-1:0] acc;
  logic signed [OUT_SIZE-1:0] part_0;
  logic signed [OUT_SIZE-1:0] part_1;
  logic signed [ACC_SIZE-1:0] chunk_sum;
  logic                       active;
  logic                       issue;
  logic                       retire;

  assign active        = (state == S_RUN) || (state == S_DRAIN);
  // Gating with abort_i keeps a chunk from being accepted in a cycle that is being thrown away.
  assign chunk_ready_o = (state == S_RUN) && (issued < len_q) && !abort_i;
  assign issue         = chunk_valid_i && chunk_ready_o;
  assign retire        = active && vld_sr[ARR_LAT-1];
  assign res_valid_o   = (state == S_DONE) && !abort_i;
  assign res_o         = acc;
  assign busy_o        = (state != S_IDLE);

  assign part_0    = arr_out_i[OUT_SIZE-1:0];
  assign part_1    = arr_out_i[2*OUT_SIZE-1:OUT_SIZE];
  assign chunk_sum = {{(ACC_SIZE-OUT_SIZE){part_0[OUT_SIZE-1]}}, part_0}
                   + {{(ACC_SIZE-OUT_SIZE){part_1[OUT_SIZE-1]}}, part_1};

  // Bit k set means the chunk issued k+1 edges ago is in flight; the tail lines up with arr_out_i.
  if (ARR_LAT == 1) begin : g_sr_one
    assign vld_sr_nxt = issue;
  end else begin : g_sr_deep
    assign vld_sr_nxt = {vld_sr[ARR_LAT-2:0], issue};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      len_q      <= '0;
      issued     <= '0;
      retired    <= '0;
      vld_sr     <= '0;
      acc        <= '0;
      arr_in_0_o <= '0;
      arr_in_1_o <= '0;
    end else if (abort_i) begin
      state   <= S_IDLE;
      issued  <= '0;
      retired <= '0;
      vld_sr  <= '0;
      acc     <= '0;
    end else begin
      vld_sr <= active ? vld_sr_nxt : '0;
      if (issue) begin
        arr_in_0_o <= chunk_a_i;
        arr_in_1_o <= chunk_b_i;
        issued     <= issued + LEN_W'(1);
      end
      if (retire) begin
        acc     <= acc + chunk_sum;
        retired <= retired + LEN_W'(1);
      end
      case (state)
        S_IDLE: begin
          if (start_i) begin
            len_q   <= (len_i > MAX_LEN_L) ? MAX_LEN_L : len_i;
            issued  <= '0;
            retired <= '0;
            vld_sr  <= '0;
            acc     <= '0;
            state   <= (len_i == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (issue && (issued + LEN_W'(1) == len_q)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (retire && (retired + LEN_W'(1) == len_q)) state <= S_DONE;
        end
        S_DONE: begin
          if (res_ready_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
